// File: rtl/adc_capture_if.sv
`default_nettype none
// ============================================================================
//  adc_capture_if : arm/trigger/config inputs and FIFO/status outputs of the
//                   ADC capture sequencer.           Revision: 1.0
// ============================================================================
interface adc_capture_if #(
  parameter int CNT_W = 32,
  parameter int DS_W  = 13
);
  logic             arm_i;
  logic             trigger_i;
  logic [CNT_W-1:0] presamples_i;
  logic [CNT_W-1:0] samples_i;
  logic [DS_W-1:0]  downsample_i;
  logic             fifo_full_i;

  logic             fifo_wr_o;
  logic             fifo_drop_o;
  logic             capturing_o;
  logic             done_o;
  logic             overflow_o;
  logic             cfg_err_o;
  logic             trig_early_o;
  logic [CNT_W-1:0] samples_o;
  logic [2:0]       state_o;

  modport master (
    output arm_i, trigger_i, presamples_i, samples_i, downsample_i, fifo_full_i,
    input  fifo_wr_o, fifo_drop_o, capturing_o, done_o, overflow_o, cfg_err_o,
           trig_early_o, samples_o, state_o
  );

  modport slave (
    input  arm_i, trigger_i, presamples_i, samples_i, downsample_i, fifo_full_i,
    output fifo_wr_o, fifo_drop_o, capturing_o, done_o, overflow_o, cfg_err_o,
           trig_early_o, samples_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/adc_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  adc_capture_sequencer : ADC fast-FIFO write sequencer (arm, presample,
//                          trigger wait, post-trigger, done) with downsampling.
//  Revision: 1.0
// ============================================================================
module adc_capture_sequencer #(
  parameter int CNT_W = 32,
  parameter int DS_W  = 13
) (
  input  logic         adc_sampleclk,
  input  logic         reset,
  adc_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DS_W-1:0]  DS_ONE  = {{(DS_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_TRIG = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             arm_q;
  logic             trig_q;
  logic [CNT_W-1:0] pre_lat;
  logic [CNT_W-1:0] smp_lat;
  logic [DS_W-1:0]  ds_lat;
  logic [DS_W-1:0]  ds_ctr;
  logic [CNT_W-1:0] pre_cnt;
  logic [CNT_W-1:0] post_cnt;
  logic [CNT_W-1:0] held;
  logic             wr_q;
  logic             drop_q;
  logic             ovf_q;
  logic             cfg_q;
  logic             early_q;

  logic             arm_rise;
  logic             trig_rise;
  logic             active;
  logic             strobe;
  logic             entering;
  logic [CNT_W-1:0] post_target;
  logic             wr_nx;
  logic             drop_nx;
  logic             accept;
  logic             reject;
  logic             ovf_set;
  logic             early_set;
  logic             pre_inc;
  logic             post_inc;

  assign arm_rise    = bus.arm_i & ~arm_q;
  assign trig_rise   = bus.trigger_i & ~trig_q;
  assign active      = (state == S_PRE) || (state == S_WAIT) || (state == S_TRIG);
  assign strobe      = active && (ds_ctr == ds_lat);
  assign post_target = smp_lat - pre_lat;
  assign entering    = (state_nx != state) &&
                       ((state_nx == S_PRE) || (state_nx == S_WAIT) || (state_nx == S_TRIG));

  always_comb begin
    state_nx  = state;
    wr_nx     = 1'b0;
    drop_nx   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    ovf_set   = 1'b0;
    early_set = 1'b0;
    pre_inc   = 1'b0;
    post_inc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (arm_rise) begin
          if (bus.samples_i <= bus.presamples_i) begin
            reject = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = (bus.presamples_i == '0) ? S_WAIT : S_PRE;
          end
        end
      end
      S_PRE: begin
        if (!bus.arm_i) begin
          state_nx = S_IDLE;
        end else begin
          // A trigger edge here, including on the PRE->WAIT cycle, is only flagged.
          early_set = trig_rise;
          if (strobe) begin
            if (bus.fifo_full_i) begin
              ovf_set  = 1'b1;
              state_nx = S_DONE;
            end else begin
              wr_nx   = 1'b1;
              pre_inc = 1'b1;
              if (pre_cnt + CNT_ONE == pre_lat) state_nx = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (!bus.arm_i) begin
          state_nx = S_IDLE;
        end else if (trig_rise) begin
          state_nx = S_TRIG;
          // The strobe coinciding with the trigger edge is post-trigger sample 1.
          if (strobe) begin
            if (bus.fifo_full_i) begin
              ovf_set  = 1'b1;
              state_nx = S_DONE;
            end else begin
              wr_nx    = 1'b1;
              post_inc = 1'b1;
              if (post_target == CNT_ONE) state_nx = S_DONE;
            end
          end
        end else if (strobe && (pre_lat != '0)) begin
          // Write-with-drop keeps occupancy constant, so full is irrelevant here.
          wr_nx   = 1'b1;
          drop_nx = 1'b1;
        end
      end
      S_TRIG: begin
        if (!bus.arm_i) begin
          state_nx = S_IDLE;
        end else if (strobe) begin
          if (bus.fifo_full_i) begin
            ovf_set  = 1'b1;
            state_nx = S_DONE;
          end else begin
            wr_nx    = 1'b1;
            post_inc = 1'b1;
            if (post_cnt + CNT_ONE == post_target) state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!bus.arm_i) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      state    <= S_IDLE;
      arm_q    <= 1'b0;
      trig_q   <= 1'b0;
      pre_lat  <= '0;
      smp_lat  <= '0;
      ds_lat   <= '0;
      ds_ctr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      held     <= '0;
      wr_q     <= 1'b0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cfg_q    <= 1'b0;
      early_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      arm_q  <= bus.arm_i;
      trig_q <= bus.trigger_i;
      wr_q   <= wr_nx;
      drop_q <= drop_nx;

      if (entering) begin
        ds_ctr <= '0;
      end else if (active) begin
        ds_ctr <= strobe ? '0 : ds_ctr + DS_ONE;
      end

      if (accept) begin
        pre_lat <= bus.presamples_i;
        smp_lat <= bus.samples_i;
        ds_lat  <= bus.downsample_i;
      end

      if (accept) begin
        pre_cnt  <= '0;
        post_cnt <= '0;
      end else begin
        if (pre_inc)  pre_cnt  <= pre_cnt + CNT_ONE;
        if (post_inc) post_cnt <= post_cnt + CNT_ONE;
      end

      if (accept || reject) begin
        ovf_q   <= 1'b0;
        early_q <= 1'b0;
        cfg_q   <= reject;
        held    <= '0;
      end else begin
        if (ovf_set)   ovf_q   <= 1'b1;
        if (early_set) early_q <= 1'b1;
        if (wr_q && !drop_q && (held != '1)) held <= held + CNT_ONE;
      end
    end
  end

  assign bus.fifo_wr_o    = wr_q;
  assign bus.fifo_drop_o  = drop_q;
  assign bus.capturing_o  = active;
  assign bus.done_o       = (state == S_DONE);
  assign bus.overflow_o   = ovf_q;
  assign bus.cfg_err_o    = cfg_q;
  assign bus.trig_early_o = early_q;
  assign bus.samples_o    = held;
  assign bus.state_o      = state;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_adc_capture_sequencer : self-checking bench, directed and randomized
//                             captures against an arithmetic timeline model.
//  Revision: 1.0
// ============================================================================
module tb_adc_capture_sequencer;
  localparam int CNT_W = 32;
  localparam int DS_W  = 13;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  adc_capture_if #(.CNT_W(CNT_W), .DS_W(DS_W)) bus ();

  adc_capture_sequencer #(.CNT_W(CNT_W), .DS_W(DS_W)) dut (
    .adc_sampleclk (clk),
    .reset         (reset),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"},   64'(bus.state_o),      64'(0));
    chk({tag, "_wr"},      64'(bus.fifo_wr_o),    64'(0));
    chk({tag, "_drop"},    64'(bus.fifo_drop_o),  64'(0));
    chk({tag, "_capt"},    64'(bus.capturing_o),  64'(0));
    chk({tag, "_done"},    64'(bus.done_o),       64'(0));
    chk({tag, "_ovf"},     64'(bus.overflow_o),   64'(0));
    chk({tag, "_cfgerr"},  64'(bus.cfg_err_o),    64'(0));
    chk({tag, "_early"},   64'(bus.trig_early_o), 64'(0));
    chk({tag, "_samples"}, 64'(bus.samples_o),    64'(0));
  endtask

  // Capture timeline from the arm edge (interval c = after posedge c):
  // PRE lasts p*(d+1) cycles, trigger edge at WAIT offset w, then the
  // remaining post samples arrive every d+1 cycles.
  task automatic run_capture(input string name, input int p, input int s, input int d,
                             input int w_in, input bit early, input int ej,
                             input bit want_ovf, input bit wfull);
    int k, l, r, e, w, cf, st, exp_samples;
    bit edge_wr, ew, ed;
    k = d + 1;
    l = p * k;
    w = w_in;
    if (early && (ej == l - 1) && (w == 0)) w = 1;
    edge_wr = ((w + 1) % k) == 0;
    r = (s - p) - (edge_wr ? 1 : 0);
    e = l + 1 + w + r * k;
    cf = -1;
    if (want_ovf && r >= 1) cf = l + 1 + w + int'($urandom_range(1, r)) * k;

    bus.presamples_i = CNT_W'(p);
    bus.samples_i    = CNT_W'(s);
    bus.downsample_i = DS_W'(d);
    bus.arm_i        = 1'b1;
    exp_samples      = 0;
    for (int c = 0; c <= e + 2; c++) begin
      bus.trigger_i   = (c == l + 1 + w) || (early && (c == ej + 1));
      bus.fifo_full_i = (wfull && (c >= l + 1) && (c <= l + w)) || (c == cf);
      if (c == 1) begin
        bus.presamples_i = $urandom;
        bus.samples_i    = $urandom;
        bus.downsample_i = DS_W'($urandom);
      end
      @(negedge clk);
      ew = 1'b0;
      ed = 1'b0;
      if (c < l) st = 1;
      else if (c <= l + w) st = 2;
      else if (c < e) st = 3;
      else st = 4;
      if ((c >= 1) && (c <= l) && (c % k == 0)) begin
        ew = 1'b1;
      end else if ((c >= l + 1) && (c <= l + 1 + w) && ((c - l) % k == 0)) begin
        if (c == l + 1 + w) ew = 1'b1;
        else begin
          ew = (p > 0);
          ed = (p > 0);
        end
      end else if ((c >= l + 2 + w) && (c <= e) && ((c - l - 1 - w) % k == 0)) begin
        ew = 1'b1;
      end
      if ((cf >= 0) && (c >= cf)) begin
        st = 4;
        ew = 1'b0;
        ed = 1'b0;
      end
      chk($sformatf("%s_state_c%0d", name, c),   64'(bus.state_o),     64'(st));
      chk($sformatf("%s_wr_c%0d", name, c),      64'(bus.fifo_wr_o),   64'(ew));
      chk($sformatf("%s_drop_c%0d", name, c),    64'(bus.fifo_drop_o), 64'(ed));
      chk($sformatf("%s_samples_c%0d", name, c), 64'(bus.samples_o),   64'(exp_samples));
      chk($sformatf("%s_capt_c%0d", name, c),    64'(bus.capturing_o), 64'(st >= 1 && st <= 3));
      chk($sformatf("%s_done_c%0d", name, c),    64'(bus.done_o),      64'(st == 4));
      if (ew && !ed) exp_samples++;
    end
    chk({name, "_early"},  64'(bus.trig_early_o), 64'(early));
    chk({name, "_ovf"},    64'(bus.overflow_o),   64'(cf >= 0));
    chk({name, "_cfgerr"}, 64'(bus.cfg_err_o),    64'(0));
    if (cf < 0) chk({name, "_total"}, 64'(bus.samples_o), 64'(s));
    bus.arm_i       = 1'b0;
    bus.trigger_i   = 1'b0;
    bus.fifo_full_i = 1'b0;
    @(negedge clk);
    chk({name, "_idle_state"}, 64'(bus.state_o),   64'(0));
    chk({name, "_idle_done"},  64'(bus.done_o),    64'(0));
    chk({name, "_held"},       64'(bus.samples_o), 64'(exp_samples));
  endtask

  initial begin
    int p, s, d, w, ej;
    bit early;
    reset            = 1'b1;
    bus.arm_i        = 1'b0;
    bus.trigger_i    = 1'b0;
    bus.fifo_full_i  = 1'b0;
    bus.presamples_i = '0;
    bus.samples_i    = '0;
    bus.downsample_i = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_capture("basic",  4, 10, 0, 15, 1'b0, 0, 1'b0, 1'b0);
    run_capture("ds2",    0, 3,  2, 4,  1'b0, 0, 1'b0, 1'b0);
    run_capture("early",  8, 12, 0, 3,  1'b1, 2, 1'b0, 1'b0);
    run_capture("ovf",    2, 7,  1, 1,  1'b0, 0, 1'b1, 1'b1);
    run_capture("edgeon", 3, 4,  0, 0,  1'b1, 2, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(0, 5));
      s = p + int'($urandom_range(1, 5));
      d = int'($urandom_range(0, 3));
      w = int'($urandom_range(0, 2 * (d + 1) + 1));
      early = (p > 0) && ($urandom_range(0, 1) == 1);
      ej = early ? int'($urandom_range(0, p * (d + 1) - 1)) : 0;
      run_capture($sformatf("rnd%0d", i), p, s, d, w, early, ej,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    // Rejected configuration, then an accepted re-arm.
    bus.presamples_i = 5;
    bus.samples_i    = 5;
    bus.arm_i        = 1'b1;
    @(negedge clk);
    chk("cfg_err_set",   64'(bus.cfg_err_o), 64'(1));
    chk("cfg_state",     64'(bus.state_o),   64'(0));
    chk("cfg_samples",   64'(bus.samples_o), 64'(0));
    @(negedge clk);
    chk("cfg_nowr",      64'(bus.fifo_wr_o), 64'(0));
    bus.arm_i = 1'b0;
    @(negedge clk);
    bus.samples_i = 6;
    bus.arm_i     = 1'b1;
    @(negedge clk);
    chk("cfg_err_clr",   64'(bus.cfg_err_o), 64'(0));
    chk("cfg_rearm_pre", 64'(bus.state_o),   64'(1));
    bus.arm_i = 1'b0;
    @(negedge clk);
    chk("cfg_abort",     64'(bus.state_o),   64'(0));
    chk("cfg_abort_wr",  64'(bus.fifo_wr_o), 64'(0));

    // Abort during TRIG keeps sticky flags and lets the pending write out.
    bus.presamples_i = 2;
    bus.samples_i    = 10;
    bus.downsample_i = 0;
    bus.arm_i        = 1'b1;
    @(negedge clk);
    bus.trigger_i = 1'b1;
    @(negedge clk);
    chk("abt_early", 64'(bus.trig_early_o), 64'(1));
    chk("abt_pre",   64'(bus.state_o),      64'(1));
    bus.trigger_i = 1'b0;
    @(negedge clk);
    chk("abt_wait",  64'(bus.state_o),      64'(2));
    bus.trigger_i = 1'b1;
    @(negedge clk);
    chk("abt_trig",  64'(bus.state_o),      64'(3));
    chk("abt_edgewr", 64'(bus.fifo_wr_o),   64'(1));
    bus.trigger_i = 1'b0;
    @(negedge clk);
    bus.arm_i = 1'b0;
    chk("abt_pend_wr", 64'(bus.fifo_wr_o),  64'(1));
    @(negedge clk);
    chk("abt_idle",  64'(bus.state_o),      64'(0));
    chk("abt_done",  64'(bus.done_o),       64'(0));
    chk("abt_keep",  64'(bus.trig_early_o), 64'(1));
    chk("abt_nowr",  64'(bus.fifo_wr_o),    64'(0));

    // Reset in the middle of PRE.
    bus.presamples_i = 8;
    bus.samples_i    = 12;
    bus.arm_i        = 1'b1;
    @(negedge clk);
    bus.trigger_i = 1'b1;
    @(negedge clk);
    bus.trigger_i = 1'b0;
    @(negedge clk);
    chk("rst_pre_early", 64'(bus.trig_early_o), 64'(1));
    chk("rst_pre_state", 64'(bus.state_o),      64'(1));
    reset     = 1'b1;
    bus.arm_i = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.trigger_i = c[0];
      @(negedge clk);
      chk($sformatf("post_rst_wr_%0d", c),    64'(bus.fifo_wr_o), 64'(0));
      chk($sformatf("post_rst_state_%0d", c), 64'(bus.state_o),   64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
